// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the count-up stopwatch: FSM states, digit widths
// and per-digit rollover limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam int ML_W   = 10;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 6;

    localparam logic [ML_W-1:0]  MS_MAX  = 10'd999;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/ms_prescaler.sv
// Divides clk_i down to a one-cycle millisecond tick; the partial count is held
// while disabled so a stop/start pair never loses a fraction of a millisecond.
module ms_prescaler #(
    parameter int CLK_PER_MS = 1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = enable && (cnt_reg == LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_up.sv
// Count-up stopwatch (hh:mm:ss.mmm) that saturates at HOUR_MAX:59:59.999.
// Define STOPWATCH_LAP_EN to add the lap capture register with valid/ready drain.
module stopwatch_up
    import stopwatch_pkg::*;
#(
    parameter int CLK_PER_MS = 1,
    parameter int HOUR_MAX   = 23
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              clear_i,
    output logic [ML_W-1:0]   ml_o,
    output logic [SEC_W-1:0]  sec_o,
    output logic [MIN_W-1:0]  min_o,
    output logic [HOUR_W-1:0] hour_o,
    output logic              running_o,
    output logic              sat_o
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic              lap_i,
    input  logic              lap_ready_i,
    output logic              lap_valid_o,
    output logic [ML_W-1:0]   lap_ml_o,
    output logic [SEC_W-1:0]  lap_sec_o,
    output logic [MIN_W-1:0]  lap_min_o,
    output logic [HOUR_W-1:0] lap_hour_o,
    output logic              lap_ovf_o
`endif
);

    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX);

    state_t              state_reg, state_next;
    logic [ML_W-1:0]     ml_reg, ml_next;
    logic [SEC_W-1:0]    sec_reg, sec_next;
    logic [MIN_W-1:0]    min_reg, min_next;
    logic [HOUR_W-1:0]   hour_reg, hour_next;
    logic                running_reg, sat_reg;
    logic                tick;
    logic                at_max;

    ms_prescaler #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_prescaler (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .enable   (state_reg == RUN),
        .clear    (clear_i),
        .tick     (tick)
    );

    assign at_max = (ml_reg == MS_MAX) && (sec_reg == SEC_MAX) &&
                    (min_reg == MIN_MAX) && (hour_reg == HOUR_LAST);

    always_comb begin
        state_next = state_reg;
        ml_next    = ml_reg;
        sec_next   = sec_reg;
        min_next   = min_reg;
        hour_next  = hour_reg;
        case (state_reg)
            STOP: begin
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (tick && at_max) begin
                    state_next = SAT;
                end else begin
                    if (!start_i) state_next = STOP;
                    // The tick on the edge that leaves RUN still counts.
                    if (tick) begin
                        if (ml_reg == MS_MAX) begin
                            ml_next = '0;
                            if (sec_reg == SEC_MAX) begin
                                sec_next = '0;
                                if (min_reg == MIN_MAX) begin
                                    min_next  = '0;
                                    hour_next = hour_reg + 1'b1;
                                end else begin
                                    min_next = min_reg + 1'b1;
                                end
                            end else begin
                                sec_next = sec_reg + 1'b1;
                            end
                        end else begin
                            ml_next = ml_reg + 1'b1;
                        end
                    end
                end
            end
            SAT: ;
            default: state_next = STOP;
        endcase
        if (clear_i) begin
            state_next = STOP;
            ml_next    = '0;
            sec_next   = '0;
            min_next   = '0;
            hour_next  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg   <= STOP;
            ml_reg      <= '0;
            sec_reg     <= '0;
            min_reg     <= '0;
            hour_reg    <= '0;
            running_reg <= 1'b0;
            sat_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ml_reg      <= ml_next;
            sec_reg     <= sec_next;
            min_reg     <= min_next;
            hour_reg    <= hour_next;
            running_reg <= (state_next == RUN);
            sat_reg     <= (state_next == SAT);
        end
    end

    assign ml_o      = ml_reg;
    assign sec_o     = sec_reg;
    assign min_o     = min_reg;
    assign hour_o    = hour_reg;
    assign running_o = running_reg;
    assign sat_o     = sat_reg;

`ifdef STOPWATCH_LAP_EN
    logic              lap_valid_reg, lap_ovf_reg;
    logic [ML_W-1:0]   lap_ml_reg;
    logic [SEC_W-1:0]  lap_sec_reg;
    logic [MIN_W-1:0]  lap_min_reg;
    logic [HOUR_W-1:0] lap_hour_reg;

    // Captures the pre-increment time; a drain on the same edge frees the slot.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lap_valid_reg <= 1'b0;
            lap_ovf_reg   <= 1'b0;
            lap_ml_reg    <= '0;
            lap_sec_reg   <= '0;
            lap_min_reg   <= '0;
            lap_hour_reg  <= '0;
        end else if (clear_i) begin
            lap_valid_reg <= 1'b0;
            lap_ovf_reg   <= 1'b0;
            lap_ml_reg    <= '0;
            lap_sec_reg   <= '0;
            lap_min_reg   <= '0;
            lap_hour_reg  <= '0;
        end else begin
            if (lap_i && (!lap_valid_reg || lap_ready_i)) begin
                lap_valid_reg <= 1'b1;
                lap_ml_reg    <= ml_reg;
                lap_sec_reg   <= sec_reg;
                lap_min_reg   <= min_reg;
                lap_hour_reg  <= hour_reg;
            end else if (lap_ready_i) begin
                lap_valid_reg <= 1'b0;
            end
            if (lap_i && lap_valid_reg && !lap_ready_i) lap_ovf_reg <= 1'b1;
        end
    end

    assign lap_valid_o = lap_valid_reg;
    assign lap_ovf_o   = lap_ovf_reg;
    assign lap_ml_o    = lap_ml_reg;
    assign lap_sec_o   = lap_sec_reg;
    assign lap_min_o   = lap_min_reg;
    assign lap_hour_o  = lap_hour_reg;
`endif

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed bench for stopwatch_up: three instances cover the default hour limit,
// HOUR_MAX=0 saturation and a 4-cycle prescaler; lap checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_up;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic a_start, a_clear, h_start, h_clear, p_start, p_clear;
    logic [9:0] a_ml, h_ml, p_ml;
    logic [5:0] a_sec, a_min, a_hour, h_sec, h_min, h_hour, p_sec, p_min, p_hour;
    logic a_run, a_sat, h_run, h_sat, p_run, p_sat;

`ifdef STOPWATCH_LAP_EN
    logic a_lap, a_ready, a_lv, a_lovf, h_lv, h_lovf, p_lv, p_lovf;
    logic [9:0] a_lml, h_lml, p_lml;
    logic [5:0] a_lsec, a_lmin, a_lhour, h_lsec, h_lmin, h_lhour, p_lsec, p_lmin, p_lhour;
`endif

    stopwatch_up #(.CLK_PER_MS(1), .HOUR_MAX(23)) dut_a (
        .clk_i(clk), .reset_ni(rst_n), .start_i(a_start), .clear_i(a_clear),
        .ml_o(a_ml), .sec_o(a_sec), .min_o(a_min), .hour_o(a_hour),
        .running_o(a_run), .sat_o(a_sat)
`ifdef STOPWATCH_LAP_EN
        , .lap_i(a_lap), .lap_ready_i(a_ready), .lap_valid_o(a_lv),
        .lap_ml_o(a_lml), .lap_sec_o(a_lsec), .lap_min_o(a_lmin), .lap_hour_o(a_lhour),
        .lap_ovf_o(a_lovf)
`endif
    );

    stopwatch_up #(.CLK_PER_MS(1), .HOUR_MAX(0)) dut_h (
        .clk_i(clk), .reset_ni(rst_n), .start_i(h_start), .clear_i(h_clear),
        .ml_o(h_ml), .sec_o(h_sec), .min_o(h_min), .hour_o(h_hour),
        .running_o(h_run), .sat_o(h_sat)
`ifdef STOPWATCH_LAP_EN
        , .lap_i(1'b0), .lap_ready_i(1'b0), .lap_valid_o(h_lv),
        .lap_ml_o(h_lml), .lap_sec_o(h_lsec), .lap_min_o(h_lmin), .lap_hour_o(h_lhour),
        .lap_ovf_o(h_lovf)
`endif
    );

    stopwatch_up #(.CLK_PER_MS(4), .HOUR_MAX(23)) dut_p (
        .clk_i(clk), .reset_ni(rst_n), .start_i(p_start), .clear_i(p_clear),
        .ml_o(p_ml), .sec_o(p_sec), .min_o(p_min), .hour_o(p_hour),
        .running_o(p_run), .sat_o(p_sat)
`ifdef STOPWATCH_LAP_EN
        , .lap_i(1'b0), .lap_ready_i(1'b0), .lap_valid_o(p_lv),
        .lap_ml_o(p_lml), .lap_sec_o(p_lsec), .lap_min_o(p_lmin), .lap_hour_o(p_lhour),
        .lap_ovf_o(p_lovf)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Packed view: {flag1, flag0, hour, min, sec, ml}.
    function automatic logic [29:0] tv(input int h, input int m, input int s, input int ms,
                                       input bit f1, input bit f0);
        tv = {f1, f0, 6'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    function automatic string fmt(input logic [29:0] v);
        fmt = $sformatf("%0d:%0d:%0d.%0d flags=%b%b", v[27:22], v[21:16], v[15:10], v[9:0],
                        v[29], v[28]);
    endfunction

    task automatic chk(input string name, input logic [29:0] got, input logic [29:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: actual %s required %s", name, fmt(got), fmt(exp));
        end else begin
            $display("ok   %s: %s", name, fmt(got));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] got_a();
        got_a = {a_run, a_sat, a_hour, a_min, a_sec, a_ml};
    endfunction
    function automatic logic [29:0] got_h();
        got_h = {h_run, h_sat, h_hour, h_min, h_sec, h_ml};
    endfunction
    function automatic logic [29:0] got_p();
        got_p = {p_run, p_sat, p_hour, p_min, p_sec, p_ml};
    endfunction

    // Preload the time registers of a stopped instance by holding them over one edge.
    logic [9:0] pl_ml;
    logic [5:0] pl_sec, pl_min, pl_hour;

    task automatic preload_a(input int h, input int m, input int s, input int ms);
        pl_hour = 6'(h); pl_min = 6'(m); pl_sec = 6'(s); pl_ml = 10'(ms);
        force dut_a.ml_reg = pl_ml;
        force dut_a.sec_reg = pl_sec;
        force dut_a.min_reg = pl_min;
        force dut_a.hour_reg = pl_hour;
        cyc(1);
        release dut_a.ml_reg;
        release dut_a.sec_reg;
        release dut_a.min_reg;
        release dut_a.hour_reg;
    endtask

    task automatic preload_h(input int h, input int m, input int s, input int ms);
        pl_hour = 6'(h); pl_min = 6'(m); pl_sec = 6'(s); pl_ml = 10'(ms);
        force dut_h.ml_reg = pl_ml;
        force dut_h.sec_reg = pl_sec;
        force dut_h.min_reg = pl_min;
        force dut_h.hour_reg = pl_hour;
        cyc(1);
        release dut_h.ml_reg;
        release dut_h.sec_reg;
        release dut_h.min_reg;
        release dut_h.hour_reg;
    endtask

    typedef struct {
        bit start;
        bit clear;
        int ml;
        bit run;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs = '{
            '{1'b0, 1'b0, 0, 1'b0},   // idle in STOP
            '{1'b1, 1'b0, 0, 1'b1},   // STOP->RUN, no count yet
            '{1'b1, 1'b0, 1, 1'b1},
            '{1'b1, 1'b0, 2, 1'b1},
            '{1'b0, 1'b0, 3, 1'b0},   // leaving RUN still takes the tick
            '{1'b0, 1'b0, 3, 1'b0},
            '{1'b1, 1'b0, 3, 1'b1},
            '{1'b1, 1'b0, 4, 1'b1},
            '{1'b1, 1'b1, 0, 1'b0},   // clear beats start
            '{1'b1, 1'b0, 0, 1'b1},   // start still high: RUN next cycle
            '{1'b1, 1'b0, 1, 1'b1},
            '{1'b0, 1'b1, 0, 1'b0},   // clear beats tick
            '{1'b0, 1'b0, 0, 1'b0}
        };

        rst_n = 1'b0;
        {a_start, a_clear, h_start, h_clear, p_start, p_clear} = '0;
`ifdef STOPWATCH_LAP_EN
        a_lap = 1'b0;
        a_ready = 1'b0;
`endif
        cyc(2);
        chk("reset_a", got_a(), tv(0, 0, 0, 0, 0, 0));
        chk("reset_h", got_h(), tv(0, 0, 0, 0, 0, 0));
`ifdef STOPWATCH_LAP_EN
        chk("reset_lap", {a_lv, a_lovf, a_lhour, a_lmin, a_lsec, a_lml}, tv(0, 0, 0, 0, 0, 0));
`endif
        rst_n = 1'b1;
        cyc(1);

        for (int i = 0; i < 13; i++) begin
            a_start = vecs[i].start;
            a_clear = vecs[i].clear;
            cyc(1);
            chk($sformatf("vec%0d", i), got_a(), tv(0, 0, 0, vecs[i].ml, vecs[i].run, 0));
        end
        a_clear = 1'b0;

        a_start = 1'b1;
        cyc(1001);
        chk("one_second", got_a(), tv(0, 0, 1, 0, 1, 0));
        a_start = 1'b0;
        cyc(1);
        chk("stop_edge_tick", got_a(), tv(0, 0, 1, 1, 0, 0));

        preload_a(0, 0, 59, 999);
        chk("preload", got_a(), tv(0, 0, 59, 999, 0, 0));
        a_start = 1'b1;
        cyc(2);
        chk("min_carry", got_a(), tv(0, 1, 0, 0, 1, 0));
        a_start = 1'b0;
        cyc(1);

        preload_a(0, 59, 59, 999);
        a_start = 1'b1;
        cyc(2);
        chk("hour_carry", got_a(), tv(1, 0, 0, 0, 1, 0));
        a_start = 1'b0;
        cyc(1);

        preload_a(23, 59, 59, 999);
        a_start = 1'b1;
        cyc(2);
        chk("sat_h23", got_a(), tv(23, 59, 59, 999, 0, 1));
        a_start = 1'b0;
        cyc(1);
        a_clear = 1'b1;
        cyc(1);
        a_clear = 1'b0;
        chk("sat_h23_clear", got_a(), tv(0, 0, 0, 0, 0, 0));

        // Asynchronous reset in the middle of a run.
        preload_a(0, 2, 3, 456);
        a_start = 1'b1;
        cyc(3);
        chk("pre_reset", got_a(), tv(0, 2, 3, 458, 1, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", got_a(), tv(0, 0, 0, 0, 0, 0));
        a_start = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("post_reset_stop", got_a(), tv(0, 0, 0, 0, 0, 0));

`ifdef STOPWATCH_LAP_EN
        preload_a(0, 0, 0, 123);
        a_lap = 1'b1;
        cyc(1);
        chk("lap_capture", {a_lv, a_lovf, a_lhour, a_lmin, a_lsec, a_lml}, tv(0, 0, 0, 123, 1, 0));
        cyc(1);
        a_lap = 1'b0;
        chk("lap_dropped", {a_lv, a_lovf, a_lhour, a_lmin, a_lsec, a_lml}, tv(0, 0, 0, 123, 1, 1));
        preload_a(0, 0, 0, 456);
        a_lap = 1'b1;
        a_ready = 1'b1;
        cyc(1);
        a_lap = 1'b0;
        chk("lap_reload", {a_lv, a_lovf, a_lhour, a_lmin, a_lsec, a_lml}, tv(0, 0, 0, 456, 1, 1));
        cyc(1);
        a_ready = 1'b0;
        chk("lap_drain", {a_lv, a_lovf, a_lhour, a_lmin, a_lsec, a_lml}, tv(0, 0, 0, 456, 0, 1));
        a_start = 1'b1;
        cyc(2);
        a_lap = 1'b1;
        cyc(1);
        a_lap = 1'b0;
        chk("lap_preinc", {a_lv, a_lovf, a_lhour, a_lmin, a_lsec, a_lml}, tv(0, 0, 0, 457, 1, 1));
        chk("lap_preinc_time", got_a(), tv(0, 0, 0, 458, 1, 0));
        a_clear = 1'b1;
        cyc(1);
        a_clear = 1'b0;
        chk("lap_clear", {a_lv, a_lovf, a_lhour, a_lmin, a_lsec, a_lml}, tv(0, 0, 0, 0, 0, 0));
        a_start = 1'b0;
        cyc(1);
`endif

        // HOUR_MAX = 0: saturation at 00:59:59.999.
        preload_h(0, 59, 59, 999);
        h_start = 1'b1;
        cyc(2);
        chk("h0_sat", got_h(), tv(0, 59, 59, 999, 0, 1));
        h_start = 1'b0;
        cyc(2);
        h_start = 1'b1;
        cyc(2);
        chk("h0_sat_hold", got_h(), tv(0, 59, 59, 999, 0, 1));
        h_start = 1'b0;
        h_clear = 1'b1;
        cyc(1);
        h_clear = 1'b0;
        chk("h0_clear", got_h(), tv(0, 0, 0, 0, 0, 0));
        cyc(2);
        chk("h0_stop", got_h(), tv(0, 0, 0, 0, 0, 0));

        // CLK_PER_MS = 4: partial millisecond survives a stop.
        p_start = 1'b1;
        cyc(6);
        chk("p4_run6", got_p(), tv(0, 0, 0, 1, 1, 0));
        p_start = 1'b0;
        cyc(10);
        chk("p4_stop10", got_p(), tv(0, 0, 0, 1, 0, 0));
        p_start = 1'b1;
        cyc(2);
        chk("p4_run2", got_p(), tv(0, 0, 0, 1, 1, 0));
        p_start = 1'b0;
        cyc(3);
        chk("p4_retained", got_p(), tv(0, 0, 0, 2, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
